led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter N_LED, default 4, number of LED outputs; legal range 1..32.
REQ-002 Parameter CLK_HZ, default 50_000_000, clock frequency in Hz.
REQ-003 Parameter STEP_MS, default 500, pattern step period in ms.
REQ-004 Derived constant PERIOD = CLK_HZ/1000*STEP_MS cycles; must be >= 2; prescaler width = $clog2(PERIOD).
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  high: run; low: freeze prescaler and pattern.
REQ-008 mode  in  2  pattern select: 0 ROTATE, 1 BOUNCE, 2 FILL, 3 BLINK.
REQ-009 dir  in  1  ROTATE direction: 0 toward higher index, 1 toward lower index.
REQ-010 led  out  N_LED  LED drive, active-low (0 = lit), registered.
REQ-011 step  out  1  one-cycle pulse, high on the cycle the pattern advances.

Function
REQ-012 Prescaler counts 0..PERIOD-1 while en=1; at PERIOD-1 it wraps to 0 and asserts internal tick for that cycle only.
REQ-013 en=0 holds prescaler value and pattern state; no tick; en re-asserted resumes the count from the held value.
REQ-014 All pattern state and led update on the clock edge that samples tick=1; step is registered and goes high in the same cycle the new led value appears; first update occurs PERIOD cycles after reset release with en=1.
REQ-015 mode and dir are sampled only on tick; changes between ticks have no effect until the next tick.
REQ-016 Internal state: pos (0..N_LED-1), up flag, fill count (0..N_LED), blink phase, last_mode register.
REQ-017 On tick where mode != last_mode: load the new mode's first pattern (ROTATE/BOUNCE: pos=0, up=1, led bit 0 lit; FILL: count=1; BLINK: all lit); last_mode <= mode.
REQ-018 ROTATE: exactly one LED lit at pos; dir=0 pos=(pos+1) mod N_LED; dir=1 pos=(pos-1) mod N_LED; wraps N_LED-1->0 and 0->N_LED-1.
REQ-019 BOUNCE: one LED lit; pos moves up while up=1; at pos=N_LED-1 up clears and next step is N_LED-2; at pos=0 up sets; ends are not repeated (N_LED=4: 0,1,2,3,2,1,0,1...).
REQ-020 FILL: LEDs 0..count-1 lit; count increments 1..N_LED, then 0 (all off), then 1; period N_LED+1 ticks.
REQ-021 BLINK: all LEDs toggle between all-lit and all-off each tick.
REQ-022 N_LED=1: ROTATE and BOUNCE hold LED 0 lit; FILL alternates lit/off; no out-of-range index.
REQ-023 No combinational path from any input to led or step.

Reset
REQ-024 rst_n low: prescaler=0, pos=0, up=1, count=0, blink phase=0, last_mode=0, led=all 1s (all off), step=0, independent of clk.
REQ-025 Reset mid-pattern discards all state; after release, first tick behaves per REQ-017 if mode != 0, else ROTATE advances from pos=0.
REQ-026 Reset release synchronised internally (two-flop) so deassertion is clean on clk.

Structure
REQ-027 Shared package led_pkg holds the mode encodings (MODE_ROTATE, MODE_BOUNCE, MODE_FILL, MODE_BLINK) and a period-from-ms helper function.
REQ-028 Prescaler is a sub-module tick_gen (params CLK_HZ, STEP_MS; ports clk, rst_n, en, tick); pattern logic lives in led_sequencer.

Verification (CLK_HZ=1000, STEP_MS=4 -> PERIOD=4, N_LED=4 unless stated)
REQ-029 Reset then en=1, mode=0, dir=0 -> led=1111 for 4 cycles, then 1110,1101,1011,0111,1110 every 4 cycles; step pulses once per change.
REQ-030 mode=1 -> led lit index sequence 0,1,2,3,2,1,0,1 over 8 ticks.
REQ-031 mode=2 -> led 1110,1100,1000,0000,1111,1110; then mode=0 mid-period -> next tick led=1110, sequence restarts.
REQ-032 Drop en for 10 cycles at prescaler=2 -> no step, led frozen; re-enable -> next step exactly 2 cycles later.
REQ-033 Assert rst_n low asynchronously mid-cycle during BLINK -> led=1111, step=0 immediately; after release, first step after 4 cycles.
REQ-034 N_LED=1, modes 0..3 each for 4 ticks -> led never X, matches REQ-022.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: pattern mode encodings and
// the helper that turns a step period in milliseconds into clock cycles.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_ROTATE = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_FILL   = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   function automatic int unsigned period_from_ms(input int unsigned clk_hz,
                                                  input int unsigned step_ms);
      return clk_hz / 1000 * step_ms;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..PERIOD-1 while enabled and flags the wrap cycle.
module tick_gen
   import led_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int STEP_MS = 500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int unsigned PERIOD = period_from_ms(CLK_HZ, STEP_MS);
   localparam int CW = $clog2(PERIOD);
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt;

   // en gates the tick as well as the count, so a frozen counter parked on
   // LAST cannot fire repeatedly.
   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// Active-low LED pattern sequencer (rotate, bounce, fill, blink) advancing
// once per prescaler tick; led and step are fully registered.
module led_sequencer
   import led_pkg::*;
#(
   parameter int N_LED   = 4,
   parameter int CLK_HZ  = 50_000_000,
   parameter int STEP_MS = 500
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             dir,
   output logic [N_LED-1:0] led,
   output logic             step
);

   localparam int PW   = (N_LED > 1) ? $clog2(N_LED) : 1;
   localparam int CNTW = $clog2(N_LED + 1);
   localparam logic [PW-1:0]   POS_MAX    = PW'(N_LED - 1);
   localparam logic [PW-1:0]   POS_BEFORE = PW'((N_LED > 1) ? N_LED - 2 : 0);
   localparam logic [CNTW-1:0] FILL_MAX   = CNTW'(N_LED);

   // loaded stays low until the first tick after reset, so that tick always
   // loads the selected mode's first pattern (all LEDs are dark in reset).
   typedef struct packed {
      logic [PW-1:0]   pos;
      logic            up;
      logic [CNTW-1:0] fill;
      logic            phase;
      mode_e           last_mode;
      logic            loaded;
   } pat_t;

   logic [1:0]       rst_pipe;
   logic             rst_sync_n;
   logic             tick;
   mode_e            mode_in;
   pat_t             pat_q, pat_d;
   logic [N_LED-1:0] led_d;

   // Asserts immediately, deasserts two clock edges after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_sync_n = rst_pipe[1];

   tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .STEP_MS (STEP_MS)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_sync_n),
      .en    (en),
      .tick  (tick)
   );

   assign mode_in = mode_e'(mode);

   always_comb begin
      // NOTE: hold-by-default assignments first keep this block latch-free.
      pat_d = pat_q;
      led_d = led;
      if (tick) begin
         if (!pat_q.loaded || mode_in != pat_q.last_mode) begin
            pat_d.loaded    = 1'b1;
            pat_d.last_mode = mode_in;
            case (mode_in)
               MODE_ROTATE, MODE_BOUNCE: begin
                  pat_d.pos = '0;
                  pat_d.up  = 1'b1;
               end
               MODE_FILL: pat_d.fill  = CNTW'(1);
               default:   pat_d.phase = 1'b1;
            endcase
         end else begin
            case (pat_q.last_mode)
               MODE_ROTATE: begin
                  if (dir) pat_d.pos = (pat_q.pos == '0) ? POS_MAX : pat_q.pos - PW'(1);
                  else     pat_d.pos = (pat_q.pos == POS_MAX) ? '0 : pat_q.pos + PW'(1);
               end
               MODE_BOUNCE: begin
                  // A single LED has nowhere to bounce; pos stays at 0.
                  if (N_LED == 1) begin
                     pat_d.pos = '0;
                  end else if (pat_q.up) begin
                     if (pat_q.pos == POS_MAX) begin
                        pat_d.up  = 1'b0;
                        pat_d.pos = POS_BEFORE;
                     end else begin
                        pat_d.pos = pat_q.pos + PW'(1);
                     end
                  end else if (pat_q.pos == '0) begin
                     pat_d.up  = 1'b1;
                     pat_d.pos = PW'(1);
                  end else begin
                     pat_d.pos = pat_q.pos - PW'(1);
                  end
               end
               MODE_FILL: pat_d.fill = (pat_q.fill == FILL_MAX) ? '0 : pat_q.fill + CNTW'(1);
               default:   pat_d.phase = ~pat_q.phase;
            endcase
         end

         for (int i = 0; i < N_LED; i++) begin
            logic lit;
            case (pat_d.last_mode)
               MODE_ROTATE, MODE_BOUNCE: lit = (pat_d.pos == PW'(i));
               MODE_FILL:                lit = (CNTW'(i) < pat_d.fill);
               default:                  lit = pat_d.phase;
            endcase
            led_d[i] = ~lit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         // NOTE: state registers take non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         pat_q.pos       <= '0;
         pat_q.up        <= 1'b1;
         pat_q.fill      <= '0;
         pat_q.phase     <= 1'b0;
         pat_q.last_mode <= MODE_ROTATE;
         pat_q.loaded    <= 1'b0;
         led             <= '1;
         step            <= 1'b0;
      end else begin
         pat_q <= pat_d;
         led   <= led_d;
         step  <= tick;
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomised and directed bench for led_sequencer, running a 4-LED and a
// 1-LED instance side by side against a sequence-level reference model.
module tb_led_sequencer;

   localparam int P = 4;     // 1000 Hz clock, 4 ms step
   localparam int SYNC = 2;  // reset synchroniser depth

   logic       clk = 1'b0;
   logic       rst_n, en, dir;
   logic [1:0] mode;
   logic [3:0] led4;
   logic       step4;
   logic [0:0] led1;
   logic       step1;

   led_sequencer #(.N_LED(4), .CLK_HZ(1000), .STEP_MS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .led(led4), .step(step4)
   );

   led_sequencer #(.N_LED(1), .CLK_HZ(1000), .STEP_MS(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .led(led1), .step(step1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: ticks counted since the current mode was loaded.
   int         m_sync, m_presc, m_k, m_last, m_rot4;
   bit         m_loaded;
   logic [3:0] exp_led4;
   logic [0:0] exp_led1;
   logic       exp_step;
   logic [6:0] exp_v;
   wire  [6:0] got = {led4, step4, led1, step1};

   function automatic logic [31:0] lit_set(int n, int md, int k, int rot);
      logic [31:0] s = '0;
      int per, p, pos, c;
      case (md)
         0: s[rot] = 1'b1;
         1: begin
            if (n == 1) pos = 0;
            else begin
               per = 2 * n - 2;
               p   = k % per;
               pos = (p < n) ? p : per - p;
            end
            s[pos] = 1'b1;
         end
         2: begin
            c = (k + 1) % (n + 1);
            for (int i = 0; i < c; i++) s[i] = 1'b1;
         end
         default: if (k % 2 == 0) for (int i = 0; i < n; i++) s[i] = 1'b1;
      endcase
      return s;
   endfunction

   task automatic model_reset();
      m_sync = 0; m_presc = 0; m_k = 0; m_last = 0; m_rot4 = 0; m_loaded = 0;
      exp_led4 = 4'b1111; exp_led1 = 1'b1; exp_step = 1'b0;
      exp_v = {exp_led4, exp_step, exp_led1, exp_step};
   endtask

   task automatic model_edge();
      bit tick;
      logic [31:0] s4, s1;
      if (!rst_n) return;
      if (m_sync < SYNC) begin
         m_sync++;
         exp_step = 1'b0;
      end else begin
         tick = en && (m_presc == P - 1);
         if (en) m_presc = (m_presc + 1) % P;
         exp_step = tick;
         if (tick) begin
            if (!m_loaded || int'(mode) != m_last) begin
               m_loaded = 1; m_last = int'(mode); m_k = 0; m_rot4 = 0;
            end else begin
               m_k++;
               if (m_last == 0) m_rot4 = (m_rot4 + (dir ? 3 : 1)) % 4;
            end
            s4 = lit_set(4, m_last, m_k, m_rot4);
            s1 = lit_set(1, m_last, m_k, 0);
            exp_led4 = ~s4[3:0];
            exp_led1 = ~s1[0];
         end
      end
      exp_v = {exp_led4, exp_step, exp_led1, exp_step};
   endtask

   task automatic run_cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; mode = 2'd0; dir = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (got !== 7'b1111_0_1_0) $display("FAIL reset_state: got %b exp 1111_0_1_0", got);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rotate();
      logic [3:0] tbl [9] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110,
                              4'b0111, 4'b1011, 4'b1101, 4'b1110};
      int j = 0;
      // Reset release to first step is the synchroniser delay plus PERIOD.
      for (int c = 1; c <= (SYNC + 9 * P); c++) begin
         if (j == 5 && exp_step) dir = 1'b1;
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL rotate cyc%0d: got %b exp %b", c, got, exp_v);
         else n_pass++;
         if (step4) begin
            n_checks++;
            if (j < 9 && led4 === tbl[j] && (j > 0 || c == SYNC + P)) n_pass++;
            else $display("FAIL rotate_seq step%0d cyc%0d: got %b", j, c, led4);
            j++;
         end
      end
      n_checks++;
      if (j != 9) $display("FAIL rotate_steps: got %0d exp 9", j);
      else n_pass++;
      dir = 1'b0;
   endtask

   task automatic test_bounce();
      int idx [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      logic [3:0] want;
      int j = 0;
      mode = 2'd1;
      repeat (8 * P) begin
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL bounce: got %b exp %b", got, exp_v);
         else n_pass++;
         if (exp_step && j < 8) begin
            want = ~(4'b0001 << idx[j]);
            n_checks++;
            if (led4 !== want) $display("FAIL bounce_seq step%0d: got %b exp %b", j, led4, want);
            else n_pass++;
            j++;
         end
      end
   endtask

   task automatic test_fill_then_rotate();
      logic [3:0] fill_tbl [6] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b1111, 4'b1110};
      logic [3:0] rot_tbl  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      int j = 0;
      mode = 2'd2;
      repeat (6 * P + 2) begin
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL fill: got %b exp %b", got, exp_v);
         else n_pass++;
         if (exp_step && j < 6) begin
            n_checks++;
            if (led4 !== fill_tbl[j]) $display("FAIL fill_seq step%0d: got %b exp %b", j, led4, fill_tbl[j]);
            else n_pass++;
            j++;
         end
      end
      mode = 2'd0;  // mid-period switch
      j = 0;
      repeat (4 * P) begin
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL fill_to_rotate: got %b exp %b", got, exp_v);
         else n_pass++;
         if (exp_step && j < 4) begin
            n_checks++;
            if (led4 !== rot_tbl[j]) $display("FAIL restart_seq step%0d: got %b exp %b", j, led4, rot_tbl[j]);
            else n_pass++;
            j++;
         end
      end
   endtask

   task automatic test_enable_freeze();
      int lat = 0;
      for (int c = 0; c < 2 * P && m_presc != 2; c++) run_cycle();
      n_checks++;
      if (m_presc != 2) $display("FAIL freeze_align: prescaler model at %0d exp 2", m_presc);
      else n_pass++;
      en = 1'b0;
      repeat (10) begin
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL freeze_hold: got %b exp %b", got, exp_v);
         else n_pass++;
      end
      en = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL freeze_resume: got %b exp %b", got, exp_v);
         else n_pass++;
         if (step4 && lat == 0) lat = c;
      end
      n_checks++;
      if (lat != 2) $display("FAIL resume_latency: got %0d cycles exp 2", lat);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      int lat = 0;
      mode = 2'd3;
      repeat (3 * P) begin
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL blink: got %b exp %b", got, exp_v);
         else n_pass++;
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (got !== 7'b1111_0_1_0) $display("FAIL async_reset: got %b exp 1111_0_1_0", got);
      else n_pass++;
      repeat (2) run_cycle();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= SYNC + 2 * P; c++) begin
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL post_reset: got %b exp %b", got, exp_v);
         else n_pass++;
         if (step4 && lat == 0) begin
            lat = c;
            n_checks++;
            if (led4 !== 4'b0000) $display("FAIL post_reset_blink: got %b exp 0000", led4);
            else n_pass++;
         end
      end
      n_checks++;
      if (lat != SYNC + P) $display("FAIL post_reset_latency: got %0d exp %0d", lat, SYNC + P);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)  dir  = 1'($urandom_range(0, 1));
         en = ($urandom_range(0, 7) != 0);
         run_cycle();
         n_checks++;
         if (got !== exp_v) $display("FAIL random cyc%0d mode%0d: got %b exp %b", c, mode, got, exp_v);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_rotate();
      test_bounce();
      test_fill_then_rotate();
      test_enable_freeze();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
